// File: rtl/fib_stream_gen_if.sv
// Stream bundle carrying Fibonacci terms from the generator to a consumer.
// Master drives data/valid, slave drives ready.
interface fib_stream_gen_if #(
  parameter int N = 4
);

  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fib_stream_gen.sv
// Fibonacci term generator with a valid/ready output stream.
// Optional macro FIB_SKIP_DUP_EN drops the duplicate second 1.
module fib_stream_gen #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             count,
  fib_stream_gen_if.master       strm,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  logic [N-1:0] a;
  logic [N:0]   b;
  logic [7:0]   remaining;
  logic         valid;

  logic [N:0]   sum;
  logic [N:0]   nxt_a;
  logic [N:0]   nxt_b;
  logic         fire;
  logic         last;

`ifdef FIB_SKIP_DUP_EN
  logic         first;
`endif

  assign strm.out_data  = a;
  assign strm.out_valid = valid;

  assign fire = valid && strm.out_ready;
  assign last = (remaining == 8'd1);

  // Next recurrence step; the extra bit exposes terms that no longer fit.
  always_comb begin
    sum   = {1'b0, a} + b;
    nxt_a = b;
    nxt_b = sum;
`ifdef FIB_SKIP_DUP_EN
    if (first) begin
      nxt_a = sum;
      nxt_b = b + sum;
    end
`endif
  end

  // Control FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= (N+1)'(1);
      remaining <= 8'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
`ifdef FIB_SKIP_DUP_EN
      first     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a         <= '0;
            b         <= (N+1)'(1);
            remaining <= count;
            overflow  <= 1'b0;
`ifdef FIB_SKIP_DUP_EN
            first     <= 1'b1;
`endif
            if (count != 8'd0) begin
              state <= RUN;
              valid <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            remaining <= remaining - 8'd1;
            b         <= nxt_b;
`ifdef FIB_SKIP_DUP_EN
            first     <= 1'b0;
`endif
            // Keep the last in-range term when the next one overflows.
            if (!nxt_a[N]) begin
              a <= nxt_a[N-1:0];
            end
            if (last || nxt_a[N]) begin
              state    <= DONE;
              valid    <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= !last;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Table-driven bench for fib_stream_gen with a term scoreboard.
// Build with FIB_SKIP_DUP_EN to exercise the distinct-value stream.
module tb_fib_stream_gen;

  localparam int N = 4;

  typedef struct {
    int c;
    bit stall;
    bit mid;
    int beats;
    bit ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  fib_stream_gen_if #(.N(N)) bus ();

  fib_stream_gen #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .strm     (bus.master),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic push_model(input int c);
    int  a;
    int  b;
    int  na;
    int  nb;
    int  n;
    bit  first;
    a = 0;
    b = 1;
    n = 0;
    first = 1'b1;
    while (n < c) begin
      exp_q.push_back(a);
      n++;
      if (n == c) break;
      na = b;
      nb = a + b;
`ifdef FIB_SKIP_DUP_EN
      if (first) begin
        na = a + b;
        nb = b + a + b;
      end
`endif
      first = 1'b0;
      if (na >= (1 << N)) break;
      a = na;
      b = nb;
    end
  endtask

  // Called at a negedge; start is driven in that same cycle.
  task automatic run_vec(input vec_t v);
    int   beats;
    bit   got_done;
    bit   prev_stall;
    int   prev_data;
    push_model(v.c);
    start = 1'b1;
    count = 8'(v.c);
    @(posedge clk);
    beats = 0;
    got_done = 1'b0;
    prev_stall = 1'b0;
    prev_data = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = v.mid && (i == 3);
      count = start ? 8'd3 : 8'(v.c);
      bus.out_ready = v.stall ? ((i % 3) == 1) : 1'b1;
      if (i == 1 && v.c != 0)
        check("ovf_clear", overflow, 0);
      if (prev_stall)
        check("stall_hold", bus.out_data, prev_data);
      if (done) begin
        check("done_valid", bus.out_valid, 0);
        check("done_busy", busy, 0);
        check("ovf", overflow, v.ovf);
        check("beats", beats, v.beats);
        if (!v.stall)
          check("latency", i, v.beats + 1);
        check("q_empty", exp_q.size(), 0);
        got_done = 1'b1;
        break;
      end
      if (bus.out_valid) begin
        check("busy", busy, 1);
        if (bus.out_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat: got %0d required none",
                     bus.out_data);
          end else begin
            check("data", bus.out_data, exp_q.pop_front());
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
    if (!got_done) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done required done");
    end
    exp_q.delete();
  endtask

  initial begin
`ifdef FIB_SKIP_DUP_EN
    tbl.push_back('{7, 1'b0, 1'b0, 7, 1'b0});
    tbl.push_back('{9, 1'b0, 1'b0, 7, 1'b1});
    tbl.push_back('{5, 1'b1, 1'b0, 5, 1'b0});
    tbl.push_back('{0, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{7, 1'b0, 1'b1, 7, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b0, 1, 1'b0});
    tbl.push_back('{255, 1'b1, 1'b0, 7, 1'b1});
    tbl.push_back('{2, 1'b0, 1'b0, 2, 1'b0});
`else
    tbl.push_back('{8, 1'b0, 1'b0, 8, 1'b0});
    tbl.push_back('{10, 1'b0, 1'b0, 8, 1'b1});
    tbl.push_back('{5, 1'b1, 1'b0, 5, 1'b0});
    tbl.push_back('{0, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{8, 1'b0, 1'b1, 8, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b0, 1, 1'b0});
    tbl.push_back('{255, 1'b1, 1'b0, 8, 1'b1});
    tbl.push_back('{7, 1'b0, 1'b0, 7, 1'b0});
`endif

    rst = 1'b1;
    start = 1'b0;
    count = 8'd0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_data", bus.out_data, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) run_vec(tbl[k]);
    start = 1'b0;

    // Abort a run after its third beat.
    @(negedge clk);
    push_model(8);
    start = 1'b1;
    count = 8'd8;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_data", bus.out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_data", bus.out_data, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", overflow, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec('{2, 1'b0, 1'b0, 2, 1'b0});
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
